// File: rtl/decode_ctrl_stage.sv
// Instruction-decode control stage: decodes opcode/register fields into the
// RegWrite/MemWrite/MemRead/MemtoDist control set and holds them in one output
// pipeline register. Uses valid/ready on both sides, stalls one bubble on a
// load-use hazard, supports a synchronous flush and counts stall cycles.
module decode_ctrl_stage #(
   parameter int unsigned INSTR_W   = 16,
   parameter int unsigned OPC_W     = 4,
   parameter int unsigned REG_W     = 4,
   parameter int unsigned CNT_W     = 8,
   parameter bit          HAZARD_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OPC_W-1:0]   out_opcode,
   output logic [REG_W-1:0]   out_rd,
   output logic [REG_W-1:0]   out_rs,
   output logic [REG_W-1:0]   out_rt,
   output logic               out_reg_write,
   output logic               out_mem_write,
   output logic               out_mem_read,
   output logic               out_mem_to_dist,
   output logic [CNT_W-1:0]   stall_cnt
);

   // Field positions, MSB-first: opcode, rd, rs, rt.
   localparam int unsigned RD_HI = INSTR_W - OPC_W - 1;
   localparam int unsigned RS_HI = RD_HI - REG_W;
   localparam int unsigned RT_HI = RS_HI - REG_W;
   localparam int unsigned CLS_W = 4;

   // Decoded view of the incoming instruction.
   logic [OPC_W-1:0] w_opc;
   logic [CLS_W-1:0] w_cls;
   logic [REG_W-1:0] w_rd;
   logic [REG_W-1:0] w_rs;
   logic [REG_W-1:0] w_rt;
   logic             w_reg_write;
   logic             w_mem_write;
   logic             w_mem_read;
   logic             w_rt_used;

   // Handshake and next-state control.
   logic             w_hazard;
   logic             w_accept;
   logic             w_load;
   logic             w_clear;
   logic             w_stall_inc;

   // Output pipeline register.
   logic             r_valid;
   logic [OPC_W-1:0] r_opcode;
   logic [REG_W-1:0] r_rd;
   logic [REG_W-1:0] r_rs;
   logic [REG_W-1:0] r_rt;
   logic             r_reg_write;
   logic             r_mem_write;
   logic             r_mem_read;
   logic             r_mem_to_dist;
   logic [CNT_W-1:0] r_stall_cnt;

   // Field extraction; the control class is the top four opcode bits.
   always_comb begin
      w_opc = instr_in[INSTR_W-1 -: OPC_W];
      w_rd  = instr_in[RD_HI -: REG_W];
      w_rs  = instr_in[RS_HI -: REG_W];
      w_rt  = instr_in[RT_HI -: REG_W];
      w_cls = w_opc[OPC_W-1 -: CLS_W];
   end

   // Control decode: ALU ops (0xxx), 101x, 1101 and loads write a register.
   always_comb begin
      w_reg_write = 1'b0;
      w_mem_write = 1'b0;
      w_mem_read  = 1'b0;
      w_rt_used   = 1'b0;
      if (!w_cls[3])                w_reg_write = 1'b1;
      if (w_cls[3:1] == 3'b101)     w_reg_write = 1'b1;
      if (w_cls == 4'b1101)         w_reg_write = 1'b1;
      if (w_cls == 4'b1000) begin
         w_reg_write = 1'b1;
         w_mem_read  = 1'b1;
      end
      if (w_cls == 4'b1001)         w_mem_write = 1'b1;
      // rt is a source for ALU register-register ops and for stores.
      if (!w_cls[3] || (w_cls == 4'b1001)) w_rt_used = 1'b1;
   end

   // Load-use hazard: held load's destination feeds a source of the new instruction.
   always_comb begin
      w_hazard = 1'b0;
      if (HAZARD_EN && r_valid && r_mem_read) begin
         if (r_rd == w_rs)               w_hazard = 1'b1;
         if (w_rt_used && (r_rd == w_rt)) w_hazard = 1'b1;
      end
   end

   // Input handshake is combinational so a freed slot is usable the same cycle.
   always_comb begin
      in_ready    = !flush && !w_hazard && (!r_valid || out_ready);
      w_accept    = in_valid && in_ready;
      w_stall_inc = in_valid && w_hazard && !flush;
   end

   // Next-state selection: flush beats accept, accept beats drain-to-bubble.
   always_comb begin
      w_load  = 1'b0;
      w_clear = 1'b0;
      if (flush) begin
         w_clear = 1'b1;
      end else if (w_accept) begin
         w_load = 1'b1;
      end else if (r_valid && out_ready) begin
         w_clear = 1'b1;
      end
   end

   // Output pipeline register; a bubble clears every field and control bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid       <= 1'b0;
         r_opcode      <= '0;
         r_rd          <= '0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_reg_write   <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_to_dist <= 1'b0;
      end else if (w_load) begin
         r_valid       <= 1'b1;
         r_opcode      <= w_opc;
         r_rd          <= w_rd;
         r_rs          <= w_rs;
         r_rt          <= w_rt;
         r_reg_write   <= w_reg_write;
         r_mem_write   <= w_mem_write;
         r_mem_read    <= w_mem_read;
         r_mem_to_dist <= w_mem_read;
      end else if (w_clear) begin
         r_valid       <= 1'b0;
         r_opcode      <= '0;
         r_rd          <= '0;
         r_rs          <= '0;
         r_rt          <= '0;
         r_reg_write   <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_to_dist <= 1'b0;
      end
   end

   // Saturating count of cycles an offered instruction was held off by a hazard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign out_valid       = r_valid;
   assign out_opcode      = r_opcode;
   assign out_rd          = r_rd;
   assign out_rs          = r_rs;
   assign out_rt          = r_rt;
   assign out_reg_write   = r_reg_write;
   assign out_mem_write   = r_mem_write;
   assign out_mem_read    = r_mem_read;
   assign out_mem_to_dist = r_mem_to_dist;
   assign stall_cnt       = r_stall_cnt;

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered, parametrised instruction-decode control stage.
- Sits between instruction fetch and the ALU/memory datapath.
- Decodes opcode and register fields into the RegWrite, MemWrite, MemRead and MemtoDist control set and holds them in one output pipeline register.
- Uses valid/ready handshakes on both sides.
- Adds load-use hazard detection with a one-bubble stall, a synchronous flush, and a saturating stall counter.

Parameters:
- INSTR_W, 16, instruction width in bits.
- OPC_W, 4, opcode field width. Opcode is instr[INSTR_W-1 -: OPC_W]. OPC_W must be at least 4.
- REG_W, 4, width of each register field. rd, rs and rt follow the opcode, MSB-first. OPC_W+3*REG_W must not exceed INSTR_W.
- CNT_W, 8, width of the stall counter.
- HAZARD_EN, 1, set to 0 to disable hazard stalls entirely.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  an instruction is presented on instr_in.
- in_ready  out  1  the stage accepts instr_in this cycle.
- instr_in  in  INSTR_W  instruction word.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  the output register holds a decoded instruction.
- out_ready  in  1  downstream consumes the output this cycle.
- out_opcode  out  OPC_W  registered opcode.
- out_rd, out_rs, out_rt  out  REG_W each  registered register fields.
- out_reg_write, out_mem_write, out_mem_read, out_mem_to_dist  out  1 each  registered control bits.
- stall_cnt  out  CNT_W  count of hazard stall cycles, saturating.

Behaviour:
- Reset (async, rst=1): out_valid, all out_* fields, control bits and stall_cnt go to 0. Reset mid-operation drops the held instruction.
- Decode uses c = the top 4 bits of the opcode:
  - reg_write = (c[3]==0) | (c[3:1]==101) | (c==1101) | (c==1000)
  - mem_write = (c==1001)
  - mem_read = mem_to_dist = (c==1000)
- Source usage: rs is always read. rt is read when c[3]==0 or c==1001.
- hazard = HAZARD_EN & out_valid & out_mem_read & ((out_rd==rs_in) | (rt_used_in & out_rd==rt_in)).
- in_ready = !flush & !hazard & (!out_valid | out_ready). It is combinational.
- Accept (in_valid & in_ready): at the next edge the output register loads the decoded fields and out_valid=1. Latency is 1 cycle.
- Consume without accept (out_valid & out_ready & !accept): the next state is a bubble, with out_valid=0 and all out_* control bits and fields cleared. Control bits are 0 whenever out_valid=0.
- Backpressure (out_valid & !out_ready): the output register holds and is bit-stable.
- Hazard with out_ready=1: the load drains, a bubble follows, and the dependent instruction is accepted the following cycle. This is exactly one bubble.
- flush=1 has the highest priority after reset:
  - The next state is a bubble regardless of out_ready.
  - in_ready=0 that cycle, so nothing is accepted.
  - stall_cnt is unaffected.
- stall_cnt increments by 1 on each cycle with in_valid & hazard & !flush. It saturates at 2^CNT_W-1 and is cleared only by rst.
- HAZARD_EN=0: hazard is tied 0 and stall_cnt stays 0.

Test Plan:
1. Assert rst mid-stream with out_valid=1 -> out_valid and all outputs are 0 immediately, without waiting for a clock edge. After release, in_ready=1.
2. Hold out_ready=1 and present instr 0x1234 -> next cycle out_valid=1, opcode=1, rd=2, rs=3, rt=4, reg_write=1, mem_write=mem_read=mem_to_dist=0.
3. Present 0x8512 (load, rd=5), then 0x0356 (rs=5) back-to-back with out_ready=1:
   - c1: out holds the load (mem_read=1, mem_to_dist=1, reg_write=1); in_ready=0.
   - c2: out_valid=0; 0x0356 is accepted.
   - c3: out holds 0x0356.
   - stall_cnt=1.
4. Load 0x8A13, then 0x1B00 (no rs/rt match) -> no bubble, stall_cnt unchanged. Load 0x8A13, then store 0x90A0 (rs=A) -> one bubble. The store emerges with mem_write=1 and reg_write=0.
5. Backpressure: out_ready=0 for 3 cycles with 0x1234 held -> in_ready=0 and outputs stable. When out_ready=1, the next queued instruction is accepted the same cycle.
6. Flush during a hazard stall -> next cycle out_valid=0, no accept in the flush cycle, stall_cnt unchanged. With CNT_W=2, 5 hazard stall cycles -> stall_cnt=3 (saturated).
